// File: rtl/ysyx_23060096_writeback_pkg.sv
// Shared definitions for the writeback stage: load size encodings, the
// architectural zero register index and the arbitrated result record.
package ysyx_23060096_writeback_pkg;

    localparam int WB_ADDR_W = 5;
    localparam int WB_DATA_W = 32;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam int REG_ZERO = 0;

    typedef struct packed {
        logic                 wen;
        logic [WB_ADDR_W-1:0] rd;
        logic [WB_DATA_W-1:0] data;
    } wb_result_t;

endpackage

// File: rtl/ysyx_23060096_load_align.sv
// Load response formatter: selects the byte/half lane addressed by the
// offset and sign- or zero-extends it to the full register width.
module ysyx_23060096_load_align
    import ysyx_23060096_writeback_pkg::*;
#(
    parameter int DATA_WIDTH = WB_DATA_W
) (
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            size,
    input  logic                  is_unsigned,
    input  logic [1:0]            offset,
    output logic [DATA_WIDTH-1:0] data
);

    logic [DATA_WIDTH-1:0] shifted_s;
    logic                  fill_s;

    // Lane select and extension; word and reserved sizes pass straight through.
    always_comb begin
        shifted_s = rdata;
        fill_s    = 1'b0;
        data      = rdata;
        case (size)
            SZ_B: begin
                shifted_s = rdata >> {offset, 3'b000};
                fill_s    = !is_unsigned && shifted_s[7];
                data      = {{(DATA_WIDTH-8){fill_s}}, shifted_s[7:0]};
            end
            SZ_H: begin
                // Halfword lanes are 16-bit aligned, so only offset[1] matters.
                shifted_s = rdata >> {offset[1], 4'b0000};
                fill_s    = !is_unsigned && shifted_s[15];
                data      = {{(DATA_WIDTH-16){fill_s}}, shifted_s[15:0]};
            end
            default: begin
                shifted_s = rdata;
                fill_s    = 1'b0;
                data      = rdata;
            end
        endcase
    end

endmodule

// File: rtl/ysyx_23060096_writeback.sv
// Writeback stage: arbitrates EXU and LSU results (LSU first), registers the
// register-file write port and tracks in-flight load destinations for decode.
module ysyx_23060096_writeback
    import ysyx_23060096_writeback_pkg::*;
#(
    parameter int ADDR_WIDTH = WB_ADDR_W,
    parameter int DATA_WIDTH = WB_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  exu_valid,
    output logic                  exu_ready,
    input  logic                  exu_wen,
    input  logic [ADDR_WIDTH-1:0] exu_rd,
    input  logic [DATA_WIDTH-1:0] exu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_rdata,
    input  logic [1:0]            lsu_size,
    input  logic                  lsu_unsigned,
    input  logic [1:0]            lsu_offset,
    input  logic                  ld_issue,
    input  logic [ADDR_WIDTH-1:0] ld_issue_rd,
    input  logic [ADDR_WIDTH-1:0] q_ra,
    input  logic [ADDR_WIDTH-1:0] q_rb,
    output logic                  hazard_a,
    output logic                  hazard_b,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic [31:0]           commit_cnt
);

    localparam int                    NREGS    = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] RD_ZERO  = ADDR_WIDTH'(REG_ZERO);
    localparam logic [WB_ADDR_W-1:0]  SEL_ZERO = WB_ADDR_W'(REG_ZERO);
    localparam logic [NREGS-1:0]      ONE_HOT0 = {{(NREGS-1){1'b0}}, 1'b1};

    logic                  lsu_fire_s;
    logic                  exu_fire_s;
    logic                  accept_s;
    logic [DATA_WIDTH-1:0] ld_data_s;
    wb_result_t            sel_s;
    logic [NREGS-1:0]      pending_r;
    logic [NREGS-1:0]      pending_nxt_s;
    logic [NREGS-1:0]      set_mask_s;
    logic [NREGS-1:0]      clr_mask_s;

    ysyx_23060096_load_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_load_align (
        .rdata       (lsu_rdata),
        .size        (lsu_size),
        .is_unsigned (lsu_unsigned),
        .offset      (lsu_offset),
        .data        (ld_data_s)
    );

    // Fixed-priority arbitration; neither ready looks at its own valid.
    always_comb begin
        lsu_ready = 1'b0;
        exu_ready = 1'b0;
        if (rst) begin
            lsu_ready = 1'b0;
            exu_ready = 1'b0;
        end else begin
            lsu_ready = 1'b1;
            exu_ready = !lsu_valid;
        end
    end

    assign lsu_fire_s = lsu_valid && lsu_ready;
    assign exu_fire_s = exu_valid && exu_ready;
    assign accept_s   = lsu_fire_s || exu_fire_s;

    // Select the winning result; load responses always request a write.
    always_comb begin
        sel_s = '0;
        if (lsu_fire_s) begin
            sel_s.wen  = 1'b1;
            sel_s.rd   = WB_ADDR_W'(lsu_rd);
            sel_s.data = WB_DATA_W'(ld_data_s);
        end else if (exu_fire_s) begin
            sel_s.wen  = exu_wen;
            sel_s.rd   = WB_ADDR_W'(exu_rd);
            sel_s.data = WB_DATA_W'(exu_data);
        end else begin
            sel_s = '0;
        end
    end

    // Register-file write port and commit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wen     <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            commit_cnt <= 32'd0;
        end else if (accept_s) begin
            // x0 writes still commit but never reach the register file.
            rf_wen     <= sel_s.wen && (sel_s.rd != SEL_ZERO);
            rf_waddr   <= ADDR_WIDTH'(sel_s.rd);
            rf_wdata   <= DATA_WIDTH'(sel_s.data);
            commit_cnt <= commit_cnt + 32'd1;
        end else begin
            rf_wen     <= 1'b0;
        end
    end

    // Set is applied after clear so a same-edge issue to the same rd wins.
    assign clr_mask_s    = lsu_fire_s ? (ONE_HOT0 << lsu_rd) : '0;
    assign set_mask_s    = (ld_issue && (ld_issue_rd != RD_ZERO)) ? (ONE_HOT0 << ld_issue_rd) : '0;
    assign pending_nxt_s = ((pending_r & ~clr_mask_s) | set_mask_s) & ~ONE_HOT0;

    // Pending-load scoreboard.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_r <= '0;
        end else begin
            pending_r <= pending_nxt_s;
        end
    end

    // A register is unreadable while its load is in flight or its write is
    // still sitting in the output register.
    assign hazard_a = (q_ra != RD_ZERO) && (pending_r[q_ra] || (rf_wen && (rf_waddr == q_ra)));
    assign hazard_b = (q_rb != RD_ZERO) && (pending_r[q_rb] || (rf_wen && (rf_waddr == q_rb)));

endmodule

// File: tb/tb_ysyx_23060096_writeback.sv
// Scoreboard bench for the writeback stage: a driver applies directed and
// random traffic and queues expected writes; a monitor pops on each commit.
module tb_ysyx_23060096_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        exu_valid, exu_wen, lsu_valid, lsu_unsigned, ld_issue;
    logic        exu_ready, lsu_ready, hazard_a, hazard_b, rf_wen;
    logic [4:0]  exu_rd, lsu_rd, ld_issue_rd, q_ra, q_rb, rf_waddr;
    logic [31:0] exu_data, lsu_rdata, rf_wdata, commit_cnt;
    logic [1:0]  lsu_size, lsu_offset;

    always #5 clk = ~clk;

    ysyx_23060096_writeback dut (
        .clk(clk), .rst(rst),
        .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_wen(exu_wen),
        .exu_rd(exu_rd), .exu_data(exu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd),
        .lsu_rdata(lsu_rdata), .lsu_size(lsu_size), .lsu_unsigned(lsu_unsigned),
        .lsu_offset(lsu_offset), .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
        .q_ra(q_ra), .q_rb(q_rb), .hazard_a(hazard_a), .hazard_b(hazard_b),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .commit_cnt(commit_cnt)
    );

    typedef struct {
        logic        wen;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] cnt;
        int          due;
    } exp_t;

    exp_t        expq[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic        rst_at_edge = 1'b1;
    bit          mdl_pend[32];
    logic        mdl_wen = 1'b0;
    logic [4:0]  mdl_waddr = 5'd0;
    logic [31:0] mdl_cnt = 32'd0;
    logic [31:0] seen_cnt = 32'd0;

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= rst;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Load formatting from the rules: pick lane arithmetically, extend by value.
    function automatic logic [31:0] fmt(input logic [31:0] w, input logic [1:0] sz,
                                        input logic uns, input logic [1:0] off);
        longint v;
        case (sz)
            2'd0: begin
                v = longint'((w >> (8 * off)) % 256);
                if (!uns && v >= 128) v = v - 256;
            end
            2'd1: begin
                v = longint'((w >> (16 * (off / 2))) % 65536);
                if (!uns && v >= 32768) v = v - 65536;
            end
            default: v = longint'(w);
        endcase
        return v[31:0];
    endfunction

    task automatic step(input logic r,
                        input logic ev, input logic ewen, input logic [4:0] erd, input logic [31:0] ed,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] lw,
                        input logic [1:0] lsz, input logic luns, input logic [1:0] loff,
                        input logic iss, input logic [4:0] ird,
                        input logic [4:0] qa, input logic [4:0] qb,
                        input logic [32:0] ld_exp);
        exp_t e;
        logic ha, hb, acc;
        @(posedge clk);
        #2;
        rst = r; exu_valid = ev; exu_wen = ewen; exu_rd = erd; exu_data = ed;
        lsu_valid = lv; lsu_rd = lrd; lsu_rdata = lw; lsu_size = lsz;
        lsu_unsigned = luns; lsu_offset = loff; ld_issue = iss; ld_issue_rd = ird;
        q_ra = qa; q_rb = qb;
        #1;
        chk("lsu_ready", 32'(lsu_ready), r ? 32'd0 : 32'd1);
        chk("exu_ready", 32'(exu_ready), (r || lv) ? 32'd0 : 32'd1);
        ha = (qa != 5'd0) && (mdl_pend[qa] || (mdl_wen && mdl_waddr == qa));
        hb = (qb != 5'd0) && (mdl_pend[qb] || (mdl_wen && mdl_waddr == qb));
        chk("hazard_a", 32'(hazard_a), 32'(ha));
        chk("hazard_b", 32'(hazard_b), 32'(hb));
        if (r) begin
            foreach (mdl_pend[i]) mdl_pend[i] = 1'b0;
            mdl_wen = 1'b0; mdl_waddr = 5'd0; mdl_cnt = 32'd0;
        end else begin
            acc = 1'b0;
            e.due = cyc + 1;
            if (lv) begin
                e.wen = (lrd != 5'd0); e.rd = lrd;
                e.data = ld_exp[32] ? ld_exp[31:0] : fmt(lw, lsz, luns, loff);
                mdl_pend[lrd] = 1'b0;
                acc = 1'b1;
            end else if (ev) begin
                e.wen = ewen && (erd != 5'd0); e.rd = erd; e.data = ed;
                acc = 1'b1;
            end
            if (acc) begin
                mdl_cnt = mdl_cnt + 32'd1;
                e.cnt = mdl_cnt;
                expq.push_back(e);
                mdl_wen = e.wen; mdl_waddr = e.rd;
            end else begin
                mdl_wen = 1'b0;
            end
            if (iss && ird != 5'd0) mdl_pend[ird] = 1'b1;
        end
    endtask

    task automatic idle(input logic [4:0] qa, input logic [4:0] qb);
        step(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 2'd2, 1'b0, 2'd0,
             1'b0, 5'd0, qa, qb, 33'd0);
    endtask

    task automatic ld(input logic [4:0] rd, input logic [31:0] w, input logic [1:0] sz,
                      input logic uns, input logic [1:0] off, input logic [32:0] ex);
        step(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, rd, w, sz, uns, off, 1'b0, 5'd0,
             5'd0, 5'd0, ex);
    endtask

    // Monitor: every commit (count change or write strobe) pops one expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_at_edge) begin
                chk("reset rf_wen", 32'(rf_wen), 32'd0);
                chk("reset commit_cnt", commit_cnt, 32'd0);
                chk("reset rf_waddr", 32'(rf_waddr), 32'd0);
                chk("reset rf_wdata", rf_wdata, 32'd0);
                seen_cnt = 32'd0;
            end else if (rf_wen || commit_cnt != seen_cnt) begin
                if (expq.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_commit: got rf_wen=%b cnt=%0d, want no commit", rf_wen, commit_cnt);
                end else begin
                    e = expq.pop_front();
                    chk("rf_wen", 32'(rf_wen), 32'(e.wen));
                    chk("rf_waddr", 32'(rf_waddr), 32'(e.rd));
                    chk("rf_wdata", rf_wdata, e.data);
                    chk("commit_cnt", commit_cnt, e.cnt);
                end
                seen_cnt = commit_cnt;
            end else if (expq.size() > 0 && expq[0].due <= cyc) begin
                n_cmp++; n_fail++;
                $display("FAIL missing_commit: got none, want rd=%0d data=%h", expq[0].rd, expq[0].data);
                void'(expq.pop_front());
            end
        end
    end

    initial begin
        logic [31:0] ldw;
        logic [1:0]  lsz, loff;
        logic        luns;
        logic [31:0] lexp;
        rst = 1'b1; exu_valid = 1'b0; exu_wen = 1'b0; exu_rd = 5'd0; exu_data = 32'd0;
        lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_rdata = 32'd0; lsu_size = 2'd0;
        lsu_unsigned = 1'b0; lsu_offset = 2'd0; ld_issue = 1'b0; ld_issue_rd = 5'd0;
        q_ra = 5'd0; q_rb = 5'd0;

        // Reset with both sources valid, then LSU wins on release.
        repeat (2) step(1'b1, 1'b1, 1'b1, 5'd6, 32'hAAAA_0006, 1'b1, 5'd2, 32'h0000_0022,
                        2'd2, 1'b0, 2'd0, 1'b0, 5'd0, 5'd0, 5'd0, 33'd0);
        step(1'b0, 1'b1, 1'b1, 5'd6, 32'hAAAA_0006, 1'b1, 5'd2, 32'h0000_0022,
             2'd2, 1'b0, 2'd0, 1'b0, 5'd0, 5'd2, 5'd6, {1'b1, 32'h0000_0022});
        step(1'b0, 1'b1, 1'b1, 5'd6, 32'hAAAA_0006, 1'b0, 5'd0, 32'd0,
             2'd2, 1'b0, 2'd0, 1'b0, 5'd0, 5'd2, 5'd6, 33'd0);
        idle(5'd6, 5'd0);

        // Plain EXU write.
        step(1'b0, 1'b1, 1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 32'd0,
             2'd2, 1'b0, 2'd0, 1'b0, 5'd0, 5'd5, 5'd0, 33'd0);
        idle(5'd5, 5'd0);

        // Both valid: x3 from LSU, then x4 from EXU.
        step(1'b0, 1'b1, 1'b1, 5'd4, 32'h0000_0444, 1'b1, 5'd3, 32'h0000_0333,
             2'd2, 1'b0, 2'd0, 1'b0, 5'd0, 5'd3, 5'd4, {1'b1, 32'h0000_0333});
        step(1'b0, 1'b1, 1'b1, 5'd4, 32'h0000_0444, 1'b0, 5'd0, 32'd0,
             2'd2, 1'b0, 2'd0, 1'b0, 5'd0, 5'd3, 5'd4, 33'd0);
        idle(5'd3, 5'd4);

        // Load formatting table with literal expectations.
        ld(5'd10, 32'h80FF_7F01, 2'd0, 1'b0, 2'd2, {1'b1, 32'hFFFF_FFFF});
        ld(5'd11, 32'h80FF_7F01, 2'd0, 1'b1, 2'd3, {1'b1, 32'h0000_0080});
        ld(5'd12, 32'h80FF_7F01, 2'd1, 1'b0, 2'd2, {1'b1, 32'hFFFF_80FF});
        ld(5'd13, 32'h80FF_7F01, 2'd1, 1'b1, 2'd0, {1'b1, 32'h0000_7F01});
        ld(5'd14, 32'h80FF_7F01, 2'd2, 1'b0, 2'd1, {1'b1, 32'h80FF_7F01});
        ld(5'd15, 32'h80FF_7F01, 2'd1, 1'b0, 2'd1, {1'b1, 32'h0000_7F01});
        idle(5'd0, 5'd0);

        // Pending load on x7 stays visible through its writeback cycle.
        step(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 2'd2, 1'b0, 2'd0,
             1'b1, 5'd7, 5'd7, 5'd0, 33'd0);
        repeat (3) idle(5'd7, 5'd7);
        step(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h0000_0777, 2'd2, 1'b0, 2'd0,
             1'b0, 5'd0, 5'd7, 5'd0, {1'b1, 32'h0000_0777});
        repeat (3) idle(5'd7, 5'd7);

        // Same-edge issue and response on x9: set wins.
        step(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 2'd2, 1'b0, 2'd0,
             1'b1, 5'd9, 5'd0, 5'd9, 33'd0);
        step(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h0000_0999, 2'd2, 1'b0, 2'd0,
             1'b1, 5'd9, 5'd9, 5'd9, 33'd0);
        repeat (3) idle(5'd9, 5'd0);

        // EXU write to x0 commits without writing; x0 never hazards.
        step(1'b0, 1'b1, 1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0, 2'd2, 1'b0, 2'd0,
             1'b1, 5'd0, 5'd0, 5'd0, 33'd0);
        idle(5'd0, 5'd0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            ldw = $urandom; lsz = 2'($urandom_range(0, 3)); loff = 2'($urandom_range(0, 3));
            luns = 1'($urandom_range(0, 1));
            lexp = fmt(ldw, lsz, luns, loff);
            step(1'($urandom_range(0, 49) == 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                 5'($urandom_range(0, 31)), $urandom,
                 1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)), ldw,
                 lsz, luns, loff,
                 1'($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 {1'b1, lexp});
        end

        repeat (3) idle(5'd0, 5'd0);
        @(negedge clk);
        if (expq.size() != 0) begin
            n_cmp++; n_fail++;
            $display("FAIL drain: got %0d pending expectations, want 0", expq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_23060096_writeback.md
Name: ysyx_23060096_writeback

Overview:
Writeback stage directly upstream of the integer register file. It accepts results from the EXU (ALU/CSR results) and the LSU (load responses) via valid/ready handshakes, and arbitrates between them. Load data is aligned and extended. The stage drives the register file write port through a registered, one-cycle-latency output. It also keeps a scoreboard of in-flight load destinations, which decode uses to detect read-after-write hazards on the register file read ports.

Parameters:
ADDR_WIDTH, 5, register index width; 2^ADDR_WIDTH architectural registers
DATA_WIDTH, 32, register/data width

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
exu_valid  in  1  EXU result valid
exu_ready  out  1  EXU result accepted this cycle
exu_wen  in  1  EXU result writes a register
exu_rd  in  ADDR_WIDTH  EXU destination
exu_data  in  DATA_WIDTH  EXU result
lsu_valid  in  1  load response valid
lsu_ready  out  1  load response accepted this cycle
lsu_rd  in  ADDR_WIDTH  load destination
lsu_rdata  in  DATA_WIDTH  raw aligned memory word
lsu_size  in  2  0=byte, 1=half, 2=word, 3=reserved
lsu_unsigned  in  1  zero-extend when 1
lsu_offset  in  2  byte offset within word
ld_issue  in  1  decode issued a load this cycle
ld_issue_rd  in  ADDR_WIDTH  destination of issued load
q_ra  in  ADDR_WIDTH  decode read port A index
q_rb  in  ADDR_WIDTH  decode read port B index
hazard_a  out  1  q_ra not yet readable from register file
hazard_b  out  1  q_rb not yet readable from register file
rf_wen  out  1  register file write enable
rf_waddr  out  ADDR_WIDTH  register file write address
rf_wdata  out  DATA_WIDTH  register file write data
commit_cnt  out  32  count of accepted results (EXU + LSU)

Behaviour:
- Reset (rst high at a clock edge): rf_wen=0, rf_waddr=0, rf_wdata=0, commit_cnt=0, scoreboard cleared. rst overrides every concurrent event. No handshake completes in the reset cycle: exu_ready=lsu_ready=0 while rst=1.
- Arbitration (combinational): lsu_ready=1 whenever not in reset. exu_ready = !lsu_valid. LSU has fixed priority, so at most one result is accepted per cycle. Both ready signals are independent of their own valid input.
- Acceptance: on an edge with X_valid&&X_ready, the output register loads rf_waddr=rd and rf_wdata=result. rf_wen = wen && (rd!=0). For LSU, wen is implicitly 1.
- Writes to x0 complete the handshake and increment commit_cnt, but rf_wen stays 0.
- With no acceptance, rf_wen=0 on the next cycle. rf_waddr and rf_wdata hold their values.
- Latency: exactly 1 cycle from acceptance edge to rf_wen/rf_wdata visible. The register file captures the data on the following edge.
- Load formatting: the shift amount depends on lsu_size.
  - byte: shift = offset*8, take bits [7:0].
  - half: shift = offset[1]*16, take bits [15:0]; offset[0] is ignored.
  - word/reserved: no shift, offset ignored.
  - Result is sign-extended from its top bit unless lsu_unsigned=1.
- Scoreboard: one pending bit per register; bit 0 is always 0.
  - Set on ld_issue with ld_issue_rd!=0.
  - Cleared on the edge that accepts an LSU response to that rd.
  - Simultaneous set and clear of the same index: set wins.
  - A second load to an already-pending rd keeps the bit set. Decode must not issue such a load; this is not checked.
- Hazards (combinational): hazard_a = (q_ra!=0) && (pending[q_ra] || (rf_wen && rf_waddr==q_ra)). hazard_b is the same using q_rb. This covers the cycle where the write sits in the output register but is not yet in the register file.
- commit_cnt increments by 1 per accepted handshake and wraps from 0xFFFFFFFF to 0.

Decomposition:
- Shared package holds:
  - lsu_size encodings (SZ_B=0, SZ_H=1, SZ_W=2).
  - Register index constant REG_ZERO=0.
  - Handshake result typedef {wen, rd, data}.
- One sub-module: ysyx_23060096_load_align. It is purely combinational and performs the size/offset/extension logic. Arbitration, output register, scoreboard and counter stay in the top.

Test Plan:
- Reset with lsu_valid=exu_valid=1 → rf_wen=0, commit_cnt=0, no ready asserted; after release, the LSU result is accepted first.
- EXU rd=5, data=0x1234_5678, wen=1 accepted → next cycle rf_wen=1, rf_waddr=5, rf_wdata=0x12345678; commit_cnt=1.
- Both valid: LSU rd=3, EXU rd=4 → cycle 1 writes x3 while exu_ready=0; cycle 2 writes x4; commit_cnt=2.
- Load rdata=0x80FF_7F01:
  - byte, offset=2 → 0xFFFFFFFF
  - byte unsigned, offset=3 → 0x00000080
  - half, offset=2 → 0xFFFF80FF
  - half unsigned, offset=0 → 0x00007F01
  - word → 0x80FF7F01
- ld_issue rd=7; q_ra=7 → hazard_a=1 until the LSU response for x7 is accepted. It stays 1 during the following rf_wen cycle and is 0 one cycle later.
- Issue and LSU response both target x9 on the same edge → pending[9] remains 1. EXU write with rd=0 → rf_wen=0, commit_cnt increments; q_ra=0 never raises a hazard.
